// File: rtl/vec_cnt_fifo.sv
// Show-ahead record FIFO behind the popcount stage: stores {ID, popcount, Last}
// once per completed vector and backpressures upstream when full.
module vec_cnt_fifo #(
  parameter int VECTOR_WIDTH = 920,
  parameter int CNT_WIDTH    = $clog2(VECTOR_WIDTH),
  parameter int VEC_ID_WIDTH = 16,
  parameter int FIFO_DEPTH   = 16,
  parameter int PTR_WIDTH    = $clog2(FIFO_DEPTH)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [VEC_ID_WIDTH-1:0] up_ID,
  input  logic                    up_Valid,
  input  logic [CNT_WIDTH-1:0]    up_Cnt,
  input  logic                    up_CntNew,
  input  logic                    up_Last,
  output logic                    up_Ready,
  output logic [VEC_ID_WIDTH-1:0] dn_ID,
  output logic [CNT_WIDTH-1:0]    dn_Cnt,
  output logic                    dn_Last,
  output logic                    dn_Valid,
  input  logic                    dn_Ready,
  output logic [PTR_WIDTH:0]      o_Level,
  output logic                    o_Overflow
);

  localparam int REC_W = VEC_ID_WIDTH + CNT_WIDTH + 1;
  localparam logic [PTR_WIDTH:0]   LVL_FULL = (PTR_WIDTH+1)'(FIFO_DEPTH);
  localparam logic [PTR_WIDTH:0]   LVL_ONE  = (PTR_WIDTH+1)'(1);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);

  logic [REC_W-1:0]     mem_q [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH:0]   level_q, level_d;
  logic                 ovf_q, ovf_d;
  logic                 wr, rd;
  logic [REC_W-1:0]     head;

  // Flow control depends only on registered level, never on dn_Ready.
  assign up_Ready = (level_q != LVL_FULL);
  assign dn_Valid = (level_q != '0);
  assign wr       = up_Valid && up_CntNew && up_Ready;
  assign rd       = dn_Valid && dn_Ready;

  // Stale storage is masked so an empty FIFO always presents zeros.
  assign head = dn_Valid ? mem_q[rd_ptr_q] : '0;
  assign {dn_ID, dn_Cnt, dn_Last} = head;

  assign o_Level    = level_q;
  assign o_Overflow = ovf_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    ovf_d    = ovf_q | (up_Valid && up_CntNew && !up_Ready);
    if (wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({wr, rd})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && wr) mem_q[wr_ptr_q] <= {up_ID, up_Cnt, up_Last};
  end

endmodule

// File: tb/tb_vec_cnt_fifo.sv
// Bench for vec_cnt_fifo: a vector table plus directed and random sequences,
// all checked cycle by cycle against a queue-based model of the record FIFO.
module tb_vec_cnt_fifo;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] up_ID = '0;
  logic        up_Valid = 1'b0;
  logic [9:0]  up_Cnt = '0;
  logic        up_CntNew = 1'b0;
  logic        up_Last = 1'b0;
  logic        up_Ready;
  logic [15:0] dn_ID;
  logic [9:0]  dn_Cnt;
  logic        dn_Last;
  logic        dn_Valid;
  logic        dn_Ready = 1'b0;
  logic [4:0]  o_Level;
  logic        o_Overflow;

  vec_cnt_fifo dut (
    .clk(clk), .rstn(rstn),
    .up_ID(up_ID), .up_Valid(up_Valid), .up_Cnt(up_Cnt), .up_CntNew(up_CntNew),
    .up_Last(up_Last), .up_Ready(up_Ready),
    .dn_ID(dn_ID), .dn_Cnt(dn_Cnt), .dn_Last(dn_Last), .dn_Valid(dn_Valid),
    .dn_Ready(dn_Ready), .o_Level(o_Level), .o_Overflow(o_Overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: the FIFO is simply an ordered list of accepted records.
  logic [26:0] mq[$];
  logic [26:0] exp_q[$];
  logic [26:0] got_q[$];
  logic        ovf_m = 1'b0;

  typedef struct {
    logic        v, cn, lst;
    logic [15:0] id;
    logic [9:0]  cnt;
    logic        dr;
    logic        e_valid;
    logic [4:0]  e_level;
    logic [15:0] e_id;
    logic [9:0]  e_cnt;
    logic        e_last;
    logic        e_ready;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic check_state();
    chk("level", 32'(o_Level), 32'(mq.size()));
    chk("up_ready", 32'(up_Ready), 32'(mq.size() < DEPTH));
    chk("dn_valid", 32'(dn_Valid), 32'(mq.size() != 0));
    chk("overflow", 32'(o_Overflow), 32'(ovf_m));
    if (mq.size() != 0) chk("head", 32'({dn_ID, dn_Cnt, dn_Last}), 32'(mq[0]));
    else                chk("head_empty", 32'({dn_ID, dn_Cnt, dn_Last}), 32'd0);
  endtask

  task automatic step(input logic v, input logic cn, input logic lst, input logic [15:0] id,
                      input logic [9:0] cnt, input logic dr, output logic wrote);
    logic rdy_m, wr_m, rd_m;
    up_Valid = v; up_CntNew = cn; up_Last = lst; up_ID = id; up_Cnt = cnt; dn_Ready = dr;
    rdy_m = (mq.size() < DEPTH);
    wr_m  = v && cn && rdy_m;
    rd_m  = (mq.size() != 0) && dr;
    if (v && cn && !rdy_m) ovf_m = 1'b1;
    if (dn_Valid && dn_Ready) got_q.push_back({dn_ID, dn_Cnt, dn_Last});
    @(posedge clk); #1;
    if (rd_m) void'(mq.pop_front());
    if (wr_m) begin
      mq.push_back({id, cnt, lst});
      exp_q.push_back({id, cnt, lst});
    end
    wrote = wr_m;
    check_state();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    up_Valid = 1'b0; up_CntNew = 1'b0; up_Last = 1'b0; up_ID = '0; up_Cnt = '0; dn_Ready = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    mq.delete(); exp_q.delete(); got_q.delete();
    ovf_m = 1'b0;
    check_state();
  endtask

  task automatic drain(input string name, input int max_cyc);
    logic w;
    for (int i = 0; i < max_cyc && mq.size() != 0; i++) step(0, 0, 0, 0, 0, 1, w);
    step(0, 0, 0, 0, 0, 1, w);
    chk({name, "_drained"}, 32'(o_Level), 32'd0);
  endtask

  task automatic check_stream(input string name);
    chk({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      chk({name, "_rec"}, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete(); exp_q.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic w;
    logic have, pv, pcn, plst;
    logic [15:0] pid;
    logic [9:0] pcnt;
    int n_sent;

    // v cn lst id cnt dr | valid level id cnt last ready
    tbl[0] = '{1,0,0,5,0,  1, 0,0,0,0,0,1};
    tbl[1] = '{1,0,0,5,0,  1, 0,0,0,0,0,1};
    tbl[2] = '{1,0,0,5,0,  1, 0,0,0,0,0,1};
    tbl[3] = '{1,1,1,5,317,1, 1,1,5,317,1,1};
    tbl[4] = '{0,0,0,0,0,  1, 0,0,0,0,0,1};
    tbl[5] = '{0,0,0,0,0,  1, 0,0,0,0,0,1};

    do_reset();
    chk("rst_valid", 32'(dn_Valid), 32'd0);
    chk("rst_ready", 32'(up_Ready), 32'd1);

    foreach (tbl[i]) begin
      step(tbl[i].v, tbl[i].cn, tbl[i].lst, tbl[i].id, tbl[i].cnt, tbl[i].dr, w);
      chk("tbl_valid", 32'(dn_Valid), 32'(tbl[i].e_valid));
      chk("tbl_level", 32'(o_Level), 32'(tbl[i].e_level));
      chk("tbl_head", 32'({dn_ID, dn_Cnt, dn_Last}),
          32'({tbl[i].e_id, tbl[i].e_cnt, tbl[i].e_last}));
      chk("tbl_ready", 32'(up_Ready), 32'(tbl[i].e_ready));
    end
    chk("single_count", 32'(got_q.size()), 32'd1);
    check_stream("single");

    // Fill to full, stall a 17th vector, then drain while it waits.
    for (int i = 0; i < 16; i++) step(1, 1, 0, 16'(i), 10'(10 + i), 0, w);
    chk("full_level", 32'(o_Level), 32'd16);
    chk("full_ready", 32'(up_Ready), 32'd0);
    step(1, 1, 0, 16, 26, 0, w);
    step(1, 1, 0, 16, 26, 0, w);
    chk("ovf_set", 32'(o_Overflow), 32'd1);
    chk("stall_level", 32'(o_Level), 32'd16);
    step(1, 1, 0, 16, 26, 1, w);
    chk("full_rd_level", 32'(o_Level), 32'd15);
    chk("full_rd_ready", 32'(up_Ready), 32'd1);
    step(1, 1, 0, 16, 26, 1, w);
    chk("rdwr_level", 32'(o_Level), 32'd15);
    drain("fill", 40);
    chk("fill_count", 32'(got_q.size()), 32'd17);
    for (int i = 0; i < got_q.size(); i++) chk("fill_id", 32'(got_q[i][26:11]), 32'(i));
    check_stream("fill");

    // Steady streaming at one record per cycle.
    for (int i = 0; i < 20; i++) begin
      step(1, 1, 0, 16'(100 + i), 10'(3 * i), 1, w);
      chk("stream_le1", 32'(o_Level <= 5'd1), 32'd1);
    end
    step(0, 0, 0, 0, 0, 1, w);
    chk("stream_tput", 32'(got_q.size()), 32'd20);
    check_stream("stream");

    // Random traffic across several pointer wraps; stalled counts are held.
    n_sent = 0; have = 1'b0;
    pv = 0; pcn = 0; plst = 0; pid = 0; pcnt = 0;
    for (int c = 0; c < 3000 && n_sent < 40; c++) begin
      if (!have) begin
        pv   = ($urandom_range(0, 3) != 0);
        pcn  = ($urandom_range(0, 2) != 0);
        plst = 1'($urandom_range(0, 1));
        pid  = 16'(200 + n_sent);
        pcnt = 10'($urandom_range(0, 920));
        have = 1'b1;
      end
      step(pv, pcn, plst, pid, pcnt, 1'($urandom_range(0, 1)), w);
      if (w) begin
        n_sent++;
        have = 1'b0;
      end else if (!(pv && pcn)) have = 1'b0;
    end
    chk("rand_sent", 32'(n_sent), 32'd40);
    drain("rand", 100);
    chk("rand_count", 32'(got_q.size()), 32'd40);
    check_stream("rand");

    // Reset with records in flight.
    for (int i = 0; i < 7; i++) step(1, 1, 0, 16'(300 + i), 10'(i), 0, w);
    chk("pre_rst_level", 32'(o_Level), 32'd7);
    do_reset();
    chk("mid_rst_valid", 32'(dn_Valid), 32'd0);
    chk("mid_rst_level", 32'(o_Level), 32'd0);
    chk("mid_rst_ovf", 32'(o_Overflow), 32'd0);
    chk("mid_rst_ready", 32'(up_Ready), 32'd1);
    step(1, 0, 0, 77, 0, 1, w);
    step(1, 1, 0, 77, 500, 1, w);
    step(0, 0, 0, 0, 0, 1, w);
    step(0, 0, 0, 0, 0, 1, w);
    chk("post_rst_count", 32'(got_q.size()), 32'd1);
    if (got_q.size() != 0) chk("post_rst_rec", 32'(got_q[0]), 32'({16'd77, 10'd500, 1'b0}));
    check_stream("post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
